bypass_ctrl: RTL and testbench
==============================

# bypass_ctrl

Parametrised operand-forwarding and load-use hazard controller for the 5-stage pipeline, sitting at the ID/EX boundary. It tracks the destinations of the instructions in EX, MEM and WB and decides each operand's forwarding source while the consumer is in ID. It registers that decision into EX and drives the EX operand muxes, generalised to NPORTS operands. It adds what a bare bypass mux lacks: a load-use stall with bubble insertion, flush/hold handling, and a write-back capture path on select code 11.

## Interface
- DATA_W, 32, operand/data width
- ADDR_W, 5, register-address width
- NPORTS, 2, number of source operands per instruction
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- hold  in  1  global freeze; all internal state holds
- flush  in  1  kill ID and EX instructions (branch/exception redirect)
- id_valid  in  1  ID holds a real instruction
- id_src  in  NPORTS*ADDR_W  source register numbers, port p at [p*ADDR_W +: ADDR_W]
- id_src_use  in  NPORTS  port p actually reads its source
- id_dst  in  ADDR_W  destination of ID instruction
- id_we  in  1  ID instruction writes id_dst
- id_is_load  in  1  ID instruction is a load (result available only at MEM/WB)
- id_reg_data  in  NPORTS*DATA_W  register-file read data in ID
- ex_mem_data  in  DATA_W  result of instruction currently in MEM
- mem_wb_data  in  DATA_W  result of instruction currently in WB
- stall  out  1  load-use stall request to fetch/decode (combinational)
- ex_valid  out  1  EX holds a real (non-bubble) instruction
- ex_sel  out  NPORTS*2  registered select per port: 00 reg, 10 ex_mem, 01 mem_wb, 11 captured WB
- ex_opnd  out  NPORTS*DATA_W  forwarded operands for EX (combinational from registered state)

## Operation
- Three tracking slots, ex/mem/wb, each {valid, we, dst, is_load}. A slot "matches" port p when id_src_use[p], src≠0, slot.valid, slot.we and slot.dst==src.
- stall = id_valid & !flush & some port matches the ex slot with ex.is_load=1.
- Select priority per port (newest wins): ex match (non-load) → 10; else mem match → 01; else wb match → 11; else 00.
- For code 11, the block captures mem_wb_data into per-port capture register cap[p] on the same edge.
- Edge update when hold=0:
  - wb←mem and mem←ex.
  - ex←ID info only if id_valid & !stall & !flush; otherwise ex←bubble (valid=0, we=0).
  - ex_valid follows ex.valid.
  - ex_sel[p] and reg operand rop[p]←id_reg_data[p] are loaded likewise. A bubble loads sel=00 and rop=0.
- ex_opnd[p] = rop[p] / ex_mem_data / mem_wb_data / cap[p] for sel 00/10/01/11.
- hold=1: no register changes (slots, sel, rop, cap, ex_valid); stall still computed combinationally.
- flush with hold=0: EX gets a bubble; mem/wb slots advance normally (older instructions complete).
- Register 0 is never forwarded, even when a slot writes r0.
- A load matching only mem or wb slots forwards without stall.

## Timing
- Reset (async, rst_n=0): all slot valid/we=0, dst=0, is_load=0; ex_valid=0; ex_sel=0; rop=0; cap=0; therefore ex_opnd=0, stall=0. Release takes effect at the next edge.
- Select latency: decision in ID cycle N, registered at edge, used in EX cycle N+1.
- Load-use costs exactly one stall cycle. After the bubble edge the load sits in mem, and the consumer re-evaluates to 01.
- Simultaneous stall and flush: flush wins, stall=0, bubble inserted.
- Simultaneous hold and flush: hold wins; the requester keeps flush asserted until hold drops.
- Reset mid-stall drops all slots; the first post-reset instruction sees no matches.

## Test plan
- Back-to-back ALU: add r3 then sub r4,r3,r1 → consumer's ex_sel[0]=10, ex_opnd[0]=ex_mem_data (drive 0x1234_5678), stall=0.
- Gap of one: r5 producer, nop, consumer of r5 → sel=01, ex_opnd=mem_wb_data (0xDEAD_BEEF).
- Gap of two: r6 producer, two nops, consumer → sel=11. ex_opnd equals the value mem_wb_data had at the ID edge (0xCAFE_0001) even after mem_wb_data changes to 0.
- Load-use: lw r7 then add r8,r7,r7 → stall=1 for one cycle, ex_valid=0 next cycle. Both ports then sel=01 with ex_opnd=load data.
- r0 and priority: producers write r0 → consumer of r0 gets sel=00. Two producers of r9 in EX and MEM → sel=10 (newest).
- Control: hold=1 for 3 cycles freezes ex_sel/ex_opnd/ex_valid. Flush with pending load-use gives stall=0 and a bubble. rst_n low mid-stream makes every output 0 immediately.

Source files
------------

// File: rtl/bypass_ctrl.sv
// ---------------------------------------------------------------------------
// bypass_ctrl
//
// Operand-forwarding and load-use hazard controller at the ID/EX boundary of
// a 5-stage pipeline. It tracks the destinations of the instructions in EX,
// MEM and WB. For each of NPORTS source operands it chooses a forwarding
// source while the consumer is in ID, registers that choice into EX, and
// drives the EX operand muxes from the registered choice.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   hold              global freeze; no register changes
//   flush             kill the ID and EX instructions (bubble into EX)
//   id_valid          ID holds a real instruction
//   id_src            source register numbers, port p at [p*ADDR_W +: ADDR_W]
//   id_src_use        port p actually reads its source
//   id_dst, id_we     destination of the ID instruction and its write enable
//   id_is_load        ID instruction is a load
//   id_reg_data       register-file read data, port p at [p*DATA_W +: DATA_W]
//   ex_mem_data       result of the instruction currently in MEM
//   mem_wb_data       result of the instruction currently in WB
//   stall             load-use stall request (combinational)
//   ex_valid          EX holds a real (non-bubble) instruction
//   ex_sel            registered select per port:
//                     00 reg, 10 ex_mem, 01 mem_wb, 11 captured WB value
//   ex_opnd           forwarded operands for EX
// ---------------------------------------------------------------------------
module bypass_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NPORTS = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       hold,
    input  logic                       flush,
    input  logic                       id_valid,
    input  logic [NPORTS*ADDR_W-1:0]   id_src,
    input  logic [NPORTS-1:0]          id_src_use,
    input  logic [ADDR_W-1:0]          id_dst,
    input  logic                       id_we,
    input  logic                       id_is_load,
    input  logic [NPORTS*DATA_W-1:0]   id_reg_data,
    input  logic [DATA_W-1:0]          ex_mem_data,
    input  logic [DATA_W-1:0]          mem_wb_data,
    output logic                       stall,
    output logic                       ex_valid,
    output logic [NPORTS*2-1:0]        ex_sel,
    output logic [NPORTS*DATA_W-1:0]   ex_opnd
);

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_EXM = 2'b10;
    localparam logic [1:0] SEL_MWB = 2'b01;
    localparam logic [1:0] SEL_CAP = 2'b11;

    // Tracking slots. Only the EX slot needs is_load: a load that has
    // reached MEM or WB forwards like any other producer.
    logic                     ex_v_q,  ex_we_q,  ex_ld_q;
    logic [ADDR_W-1:0]        ex_dst_q;
    logic                     mem_v_q, mem_we_q;
    logic [ADDR_W-1:0]        mem_dst_q;
    logic                     wb_v_q,  wb_we_q;
    logic [ADDR_W-1:0]        wb_dst_q;

    logic [NPORTS*2-1:0]      sel_q,  sel_d;
    logic [NPORTS*DATA_W-1:0] rop_q;
    logic [NPORTS*DATA_W-1:0] cap_q;

    logic                     stall_any;
    logic                     load_id;
    logic [ADDR_W-1:0]        src_w;
    logic                     rd_w, hit_ex, hit_mem, hit_wb;

    // Per-port match and select decision; newest producer wins.
    always_comb begin
        stall_any = 1'b0;
        sel_d     = '0;
        src_w     = '0;
        rd_w      = 1'b0;
        hit_ex    = 1'b0;
        hit_mem   = 1'b0;
        hit_wb    = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            src_w   = id_src[p*ADDR_W +: ADDR_W];
            // r0 is hard-wired zero and never forwarded.
            rd_w    = id_src_use[p] && (src_w != '0);
            hit_ex  = rd_w && ex_v_q  && ex_we_q  && (ex_dst_q  == src_w);
            hit_mem = rd_w && mem_v_q && mem_we_q && (mem_dst_q == src_w);
            hit_wb  = rd_w && wb_v_q  && wb_we_q  && (wb_dst_q  == src_w);
            if (hit_ex && ex_ld_q) begin
                stall_any = 1'b1;
            end
            if (hit_ex && !ex_ld_q) begin
                sel_d[2*p +: 2] = SEL_EXM;
            end else if (hit_mem) begin
                sel_d[2*p +: 2] = SEL_MWB;
            end else if (hit_wb) begin
                sel_d[2*p +: 2] = SEL_CAP;
            end else begin
                sel_d[2*p +: 2] = SEL_REG;
            end
        end
    end

    // Flush overrides the stall: the consumer is being killed anyway.
    assign stall   = id_valid && !flush && stall_any;
    assign load_id = id_valid && !stall && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v_q    <= 1'b0;
            ex_we_q   <= 1'b0;
            ex_ld_q   <= 1'b0;
            ex_dst_q  <= '0;
            mem_v_q   <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_dst_q <= '0;
            wb_v_q    <= 1'b0;
            wb_we_q   <= 1'b0;
            wb_dst_q  <= '0;
            sel_q     <= '0;
            rop_q     <= '0;
            cap_q     <= '0;
        end else if (!hold) begin
            // Older instructions always advance, even under flush.
            wb_v_q    <= mem_v_q;
            wb_we_q   <= mem_we_q;
            wb_dst_q  <= mem_dst_q;
            mem_v_q   <= ex_v_q;
            mem_we_q  <= ex_we_q;
            mem_dst_q <= ex_dst_q;
            if (load_id) begin
                ex_v_q   <= 1'b1;
                ex_we_q  <= id_we;
                ex_ld_q  <= id_is_load;
                ex_dst_q <= id_dst;
                sel_q    <= sel_d;
                rop_q    <= id_reg_data;
                // The WB producer retires at this edge, so its result must
                // be captured now to be usable in EX next cycle.
                for (int p = 0; p < NPORTS; p++) begin
                    if (sel_d[2*p +: 2] == SEL_CAP) begin
                        cap_q[p*DATA_W +: DATA_W] <= mem_wb_data;
                    end
                end
            end else begin
                ex_v_q   <= 1'b0;
                ex_we_q  <= 1'b0;
                ex_ld_q  <= 1'b0;
                ex_dst_q <= '0;
                sel_q    <= '0;
                rop_q    <= '0;
            end
        end
    end

    assign ex_valid = ex_v_q;
    assign ex_sel   = sel_q;

    always_comb begin
        ex_opnd = '0;
        for (int p = 0; p < NPORTS; p++) begin
            case (sel_q[2*p +: 2])
                SEL_EXM: ex_opnd[p*DATA_W +: DATA_W] = ex_mem_data;
                SEL_MWB: ex_opnd[p*DATA_W +: DATA_W] = mem_wb_data;
                SEL_CAP: ex_opnd[p*DATA_W +: DATA_W] = cap_q[p*DATA_W +: DATA_W];
                default: ex_opnd[p*DATA_W +: DATA_W] = rop_q[p*DATA_W +: DATA_W];
            endcase
        end
    end

endmodule

// File: tb/tb_bypass_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bypass_ctrl
//
// Reference model: the in-flight instructions are kept as a three-entry
// list (EX, MEM, WB). A consumer operand takes its value from the newest
// in-flight writer of its register; if that writer is a load still in EX,
// the consumer must wait one cycle. Each cycle the expected outputs are
// queued and a separate monitor compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_bypass_ctrl;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NP = 2;
    localparam int W  = 2 + 2*NP + NP*DW;

    logic              clk;
    logic              rst_n;
    logic              hold;
    logic              flush;
    logic              id_valid;
    logic [NP*AW-1:0]  id_src;
    logic [NP-1:0]     id_src_use;
    logic [AW-1:0]     id_dst;
    logic              id_we;
    logic              id_is_load;
    logic [NP*DW-1:0]  id_reg_data;
    logic [DW-1:0]     ex_mem_data;
    logic [DW-1:0]     mem_wb_data;
    logic              stall;
    logic              ex_valid;
    logic [NP*2-1:0]   ex_sel;
    logic [NP*DW-1:0]  ex_opnd;

    bypass_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NPORTS(NP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hold        (hold),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_src      (id_src),
        .id_src_use  (id_src_use),
        .id_dst      (id_dst),
        .id_we       (id_we),
        .id_is_load  (id_is_load),
        .id_reg_data (id_reg_data),
        .ex_mem_data (ex_mem_data),
        .mem_wb_data (mem_wb_data),
        .stall       (stall),
        .ex_valid    (ex_valid),
        .ex_sel      (ex_sel),
        .ex_opnd     (ex_opnd)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        bit v;
        bit we;
        bit ld;
        int dst;
    } ins_t;

    ins_t            pipe[3];   // 0 = EX, 1 = MEM, 2 = WB
    int              m_age[NP]; // where EX operand comes from: 0 regfile, 1..3 pipe stage+1
    logic [DW-1:0]   m_val[NP]; // value for regfile / captured sources

    logic [W-1:0]    exp_q[$];
    int              checks = 0;
    int              errors = 0;

    function automatic int src_of(int p);
        return int'(id_src[p*AW +: AW]);
    endfunction

    // Stage+1 of the newest in-flight writer of r, or 0 if none.
    function automatic int newest_writer(int r);
        for (int a = 0; a < 3; a++)
            if (pipe[a].v && pipe[a].we && pipe[a].dst == r) return a + 1;
        return 0;
    endfunction

    function automatic int need_age(int p);
        if (!id_src_use[p] || src_of(p) == 0) return 0;
        return newest_writer(src_of(p));
    endfunction

    function automatic bit m_stall();
        if (!id_valid || flush) return 1'b0;
        for (int p = 0; p < NP; p++)
            if (need_age(p) == 1 && pipe[0].ld) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] code_of(int age);
        case (age)
            1:       return 2'b10;
            2:       return 2'b01;
            3:       return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 3; a++) pipe[a] = '{0, 0, 0, 0};
        for (int p = 0; p < NP; p++) begin
            m_age[p] = 0;
            m_val[p] = '0;
        end
    endtask

    function automatic logic [W-1:0] expect_now();
        logic [NP*2-1:0]  s;
        logic [NP*DW-1:0] o;
        s = '0;
        o = '0;
        for (int p = 0; p < NP; p++) begin
            s[2*p +: 2] = code_of(m_age[p]);
            case (m_age[p])
                1:       o[p*DW +: DW] = ex_mem_data;
                2:       o[p*DW +: DW] = mem_wb_data;
                default: o[p*DW +: DW] = m_val[p];
            endcase
        end
        return {m_stall(), pipe[0].v, s, o};
    endfunction

    task automatic model_update();
        bit take;
        int na[NP];
        logic [DW-1:0] nv[NP];
        take = id_valid && !m_stall() && !flush;
        for (int p = 0; p < NP; p++) begin
            na[p] = take ? need_age(p) : 0;
            if (!take)           nv[p] = '0;
            else if (na[p] == 0) nv[p] = id_reg_data[p*DW +: DW];
            else if (na[p] == 3) nv[p] = mem_wb_data;
            else                 nv[p] = '0;
        end
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (take) pipe[0] = '{1, id_we, id_is_load, int'(id_dst)};
        else      pipe[0] = '{0, 0, 0, 0};
        for (int p = 0; p < NP; p++) begin
            m_age[p] = na[p];
            m_val[p] = nv[p];
        end
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge with inputs already applied.
    task automatic step();
        if (!rst_n) model_reset();
        exp_q.push_back(expect_now());
        @(posedge clk);
        if (rst_n && !hold) model_update();
        @(negedge clk);
    endtask

    task automatic issue(input bit v, input int s0, input int s1, input bit [1:0] u,
                         input int dst, input bit we, input bit ld);
        id_valid   = v;
        id_src     = {AW'(s1), AW'(s0)};
        id_src_use = u;
        id_dst     = AW'(dst);
        id_we      = we;
        id_is_load = ld;
        for (int p = 0; p < NP; p++) id_reg_data[p*DW +: DW] = $urandom;
        step();
    endtask

    task automatic nop();
        issue(1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (stall !== e[W-1]) begin
                    errors++;
                    $display("FAIL stall: got %0b want %0b at %0t", stall, e[W-1], $time);
                end
                checks++;
                if (ex_valid !== e[W-2]) begin
                    errors++;
                    $display("FAIL ex_valid: got %0b want %0b at %0t", ex_valid, e[W-2], $time);
                end
                checks++;
                if (ex_sel !== e[NP*DW +: 2*NP]) begin
                    errors++;
                    $display("FAIL ex_sel: got %b want %b at %0t", ex_sel, e[NP*DW +: 2*NP], $time);
                end
                checks++;
                if (ex_opnd !== e[0 +: NP*DW]) begin
                    errors++;
                    $display("FAIL ex_opnd: got %h want %h at %0t", ex_opnd, e[0 +: NP*DW], $time);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int wait_cnt;
        rst_n = 1'b0;  hold = 1'b0;  flush = 1'b0;
        id_valid = 1'b0;  id_src = '0;  id_src_use = '0;  id_dst = '0;
        id_we = 1'b0;  id_is_load = 1'b0;  id_reg_data = '0;
        ex_mem_data = '0;  mem_wb_data = '0;
        model_reset();
        @(negedge clk);
        nop();
        nop();
        rst_n = 1'b1;

        // back-to-back ALU: add r3 ; sub r4,r3,r1
        ex_mem_data = 32'h1234_5678;
        issue(1, 1, 2, 2'b11, 3, 1, 0);
        issue(1, 3, 1, 2'b11, 4, 1, 0);
        nop();
        // gap of one
        mem_wb_data = 32'hDEAD_BEEF;
        issue(1, 0, 0, 2'b00, 5, 1, 0);
        nop();
        issue(1, 5, 2, 2'b11, 11, 1, 0);
        nop();
        // gap of two, captured value survives mem_wb_data change
        issue(1, 0, 0, 2'b00, 6, 1, 0);
        nop();
        nop();
        mem_wb_data = 32'hCAFE_0001;
        issue(1, 6, 0, 2'b01, 12, 1, 0);
        mem_wb_data = 32'h0;
        nop();
        nop();
        // load-use: lw r7 ; add r8,r7,r7 (re-presented after the stall)
        issue(1, 1, 0, 2'b01, 7, 1, 1);
        issue(1, 7, 7, 2'b11, 8, 1, 0);
        mem_wb_data = 32'h0BAD_F00D;
        issue(1, 7, 7, 2'b11, 8, 1, 0);
        mem_wb_data = 32'h5A5A_1234;
        nop();
        // r0 is never forwarded
        issue(1, 0, 0, 2'b00, 0, 1, 0);
        issue(1, 0, 0, 2'b00, 0, 1, 0);
        issue(1, 0, 0, 2'b11, 13, 1, 0);
        // two producers of r9: newest wins
        issue(1, 0, 0, 2'b00, 9, 1, 0);
        issue(1, 0, 0, 2'b00, 9, 1, 0);
        issue(1, 9, 9, 2'b11, 14, 1, 0);
        // hold for 3 cycles with changing ID inputs
        hold = 1'b1;
        issue(1, 9, 3, 2'b11, 15, 1, 1);
        issue(1, 14, 9, 2'b11, 16, 1, 0);
        issue(0, 2, 2, 2'b11, 17, 1, 0);
        hold = 1'b0;
        nop();
        // flush with a pending load-use
        issue(1, 0, 0, 2'b00, 7, 1, 1);
        flush = 1'b1;
        issue(1, 7, 0, 2'b01, 18, 1, 0);
        flush = 1'b0;
        nop();
        // hold and flush together: hold wins
        issue(1, 0, 0, 2'b00, 10, 1, 0);
        hold = 1'b1;  flush = 1'b1;
        issue(1, 10, 0, 2'b01, 19, 1, 0);
        hold = 1'b0;
        issue(1, 10, 0, 2'b01, 19, 1, 0);
        flush = 1'b0;
        nop();
        // reset in the middle of a load-use stall
        issue(1, 0, 0, 2'b00, 10, 1, 1);
        issue(1, 10, 0, 2'b01, 20, 1, 0);
        rst_n = 1'b0;
        issue(1, 10, 0, 2'b01, 20, 1, 0);
        rst_n = 1'b1;
        issue(1, 10, 0, 2'b01, 20, 1, 0);
        nop();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            hold        = ($urandom_range(0, 9) == 0);
            flush       = ($urandom_range(0, 9) == 0);
            ex_mem_data = $urandom;
            mem_wb_data = $urandom;
            if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
            else                            rst_n = 1'b1;
            issue(bit'($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                  bit'($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0));
        end
        rst_n = 1'b1;
        hold  = 1'b0;
        flush = 1'b0;
        nop();

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected items left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
